// File: rtl/cla_seq_adder.sv
// Multi-cycle adder/subtractor: one 4-bit CLA slice iterated over
// WIDTH-bit operands, LSB nibble first, with a registered carry.
module cla_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);
  localparam int NSLICE = WIDTH / 4;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [CW+1:0]    base;
  logic [3:0]       s_sum;
  logic             s_cout;

  assign base = {cnt, 2'b00};

  cla_4 u_slice (
    .a    (a_q[base +: 4]),
    .b    (b_q[base +: 4]),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction folds into the add: invert B once at accept, carry-in 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub | in_cin;
            cnt     <= '0;
          end
        end
        RUN: begin
          out_sum[base +: 4] <= s_sum;
          carry_q            <= s_cout;
          if (cnt == LAST) out_cout <= s_cout;
          else             cnt      <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed + random checks for cla_seq_adder (WIDTH=16):
// vector table, latency, backpressure, mid-op reset, scoreboard.
module tb_cla_seq_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        busy;

  int total = 0;
  int bad = 0;

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n)
      assert (!(in_valid && in_ready && busy))
        else $error("accept while busy");

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("start_timeout", 0, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    in_cin = 1'($urandom);
    in_sub = 1'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (out_valid) break;
    end
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic handoff(input int stall);
    logic [15:0] s;
    logic        c;
    s = out_sum;
    c = out_cout;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_hold", {15'd0, out_valid, out_sum}, {15'd0, 1'b1, s});
      chk("stall_cout", {31'd0, out_cout}, {31'd0, c});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [16:0] ref_v;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;
    logic [15:0] bp;

    vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[2]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0};
    vecs[4]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1};
    vecs[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[8]  = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0};
    vecs[9]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1};
    vecs[10] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0};
    vecs[11] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0};

    #12;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, in_ready}, 1);
    chk("rst_sum", {16'd0, out_sum}, 0);
    chk("rst_cout", {31'd0, out_cout}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      start(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_valid(lat);
      chk($sformatf("v%0d_lat", i), lat, 5);
      chk($sformatf("v%0d_sum", i), {16'd0, out_sum}, {16'd0, vecs[i].sum});
      chk($sformatf("v%0d_cout", i), {31'd0, out_cout}, {31'd0, vecs[i].cout});
      handoff(0);
      chk($sformatf("v%0d_idle", i), {30'd0, busy, out_valid}, 0);
    end

    // Backpressure with ignored request pulses in DONE.
    start(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_valid(lat);
    bp = out_sum;
    chk("bp_sum", {16'd0, bp}, 32'h3333);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a = 16'hFFFF;
      in_b = 16'hFFFF;
      @(negedge clk);
      chk("bp_hold", {14'd0, in_ready, out_valid, out_sum},
          {14'd0, 1'b0, 1'b1, 16'h3333});
      chk("bp_cout", {31'd0, out_cout}, 0);
    end
    in_valid = 1'b1;
    in_a = 16'h0001;
    in_b = 16'h0001;
    in_cin = 1'b0;
    in_sub = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release", {29'd0, in_ready, busy, out_valid}, 32'h4);
    chk("bp_keep", {15'd0, out_cout, out_sum}, 32'h3333);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_acc", {30'd0, in_ready, busy}, 32'h1);
    wait_valid(lat);
    chk("bp_next_lat", lat, 5);
    chk("bp_next_sum", {15'd0, out_cout, out_sum}, 32'h0002);
    handoff(0);

    // Reset dropped in the second RUN cycle.
    start(16'hABCD, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {13'd0, out_valid, busy, in_ready, out_sum},
        {13'd0, 3'b001, 16'h0000});
    chk("rst_mid_cout", {31'd0, out_cout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_valid(lat);
    chk("post_rst_sum", {15'd0, out_cout, out_sum}, 32'h5555);
    handoff(0);

    for (int k = 0; k < 1500; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (rs) ref_v = {1'b0, ra} + {1'b0, ~rb} + 17'd1;
      else    ref_v = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      start(ra, rb, rc, rs);
      wait_valid(lat);
      chk("rnd_lat", lat, 5);
      chk("rnd_res", {15'd0, out_cout, out_sum}, {15'd0, ref_v});
      handoff(int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
